// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: datapath widths, reset PC and FSM state encodings.
package fetch_unit_pkg;

  localparam int unsigned FETCH_WORD      = 64;
  localparam int unsigned FETCH_INSTR_LEN = 32;
  localparam logic [63:0] FETCH_RESET_PC  = 64'h0;

  typedef enum logic [2:0] {
    FETCH_IDLE   = 3'd0,
    FETCH_REQ    = 3'd1,
    FETCH_HOLD   = 3'd2,
    FETCH_SQUASH = 3'd3,
    FETCH_FAULT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_branch_target_calc.sv
// Combinational redirect target: PC-relative word offset or absolute register target,
// plus a flag for targets that are not word aligned.
module branch_target_calc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WORD = FETCH_WORD
) (
  input  logic            redirect_kind,
  input  logic [WORD-1:0] redirect_pc,
  input  logic [WORD-1:0] redirect_offset,
  input  logic [WORD-1:0] redirect_target,
  output logic [WORD-1:0] target,
  output logic            misaligned
);

  // Select and compute the redirect destination (wraps modulo 2^WORD).
  always_comb begin
    target = redirect_target;
    if (redirect_kind == 1'b0) begin
      target = redirect_pc + (redirect_offset << 2);
    end else begin
      target = redirect_target;
    end
    misaligned = |target[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: owns the PC, keeps one imem request outstanding and
// hands each instruction to decode over valid/ready, honouring execute redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     WORD      = FETCH_WORD,
  parameter int unsigned     INSTR_LEN = FETCH_INSTR_LEN,
  parameter logic [WORD-1:0] RESET_PC  = FETCH_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 instr_valid,
  output logic [INSTR_LEN-1:0] instr,
  output logic [WORD-1:0]      instr_pc,
  input  logic                 decode_ready,
  input  logic                 redirect_valid,
  input  logic                 redirect_kind,
  input  logic [WORD-1:0]      redirect_pc,
  input  logic [WORD-1:0]      redirect_offset,
  input  logic [WORD-1:0]      redirect_target,
  output logic                 fault
);

  localparam logic [WORD-1:0] PC_STEP = {{(WORD-3){1'b0}}, 3'd4};

  fetch_state_e         state_q, state_d;
  logic [WORD-1:0]      pc_q, pc_d;
  logic                 imem_req_q, imem_req_d;
  logic [WORD-1:0]      imem_addr_q, imem_addr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [INSTR_LEN-1:0] instr_q, instr_d;
  logic [WORD-1:0]      instr_pc_q, instr_pc_d;
  logic                 fault_q, fault_d;

  logic [WORD-1:0]      target_s;
  logic                 misaligned_s;

  branch_target_calc #(.WORD(WORD)) u_target (
    .redirect_kind   (redirect_kind),
    .redirect_pc     (redirect_pc),
    .redirect_offset (redirect_offset),
    .redirect_target (redirect_target),
    .target          (target_s),
    .misaligned      (misaligned_s)
  );

  // Next-state logic; a redirect always outranks ack capture and decode consumption.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fault_d       = fault_q;

    if (redirect_valid && misaligned_s && (state_q != FETCH_FAULT)) begin
      state_d       = FETCH_FAULT;
      fault_d       = 1'b1;
      imem_req_d    = 1'b0;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          state_d    = FETCH_REQ;
          imem_req_d = 1'b1;
          if (redirect_valid) begin
            pc_d        = target_s;
            imem_addr_d = target_s;
          end else begin
            imem_addr_d = pc_q;
          end
        end
        FETCH_REQ: begin
          if (redirect_valid && imem_ack) begin
            pc_d        = target_s;
            imem_addr_d = target_s;
          end else if (redirect_valid) begin
            pc_d    = target_s;
            state_d = FETCH_SQUASH;
          end else if (imem_ack) begin
            instr_d       = imem_rdata;
            instr_pc_d    = imem_addr_q;
            instr_valid_d = 1'b1;
            imem_req_d    = 1'b0;
            pc_d          = pc_q + PC_STEP;
            state_d       = FETCH_HOLD;
          end else begin
            state_d = FETCH_REQ;
          end
        end
        FETCH_HOLD: begin
          if (redirect_valid) begin
            pc_d          = target_s;
            instr_valid_d = 1'b0;
            imem_req_d    = 1'b1;
            imem_addr_d   = target_s;
            state_d       = FETCH_REQ;
          end else if (instr_valid_q && decode_ready) begin
            instr_valid_d = 1'b0;
            imem_req_d    = 1'b1;
            imem_addr_d   = pc_q;
            state_d       = FETCH_REQ;
          end else begin
            state_d = FETCH_HOLD;
          end
        end
        FETCH_SQUASH: begin
          // The stale request must still complete; the next fetch uses the latest pc.
          if (redirect_valid && imem_ack) begin
            pc_d        = target_s;
            imem_addr_d = target_s;
            state_d     = FETCH_REQ;
          end else if (redirect_valid) begin
            pc_d = target_s;
          end else if (imem_ack) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
            state_d     = FETCH_REQ;
          end else begin
            state_d = FETCH_SQUASH;
          end
        end
        FETCH_FAULT: begin
          state_d = FETCH_FAULT;
        end
        default: begin
          state_d       = FETCH_FAULT;
          fault_d       = 1'b1;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= {WORD{1'b0}};
      instr_valid_q <= 1'b0;
      instr_q       <= {INSTR_LEN{1'b0}};
      instr_pc_q    <= {WORD{1'b0}};
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic        redirect_kind;
  logic [63:0] redirect_pc;
  logic [63:0] redirect_offset;
  logic [63:0] redirect_target;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a fetch pipe described by what is outstanding and what is held.
  logic [63:0] m_pc, m_addr, m_ipc;
  logic        m_req, m_valid, m_fault, m_discard;
  logic [31:0] m_instr;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .decode_ready    (decode_ready),
    .redirect_valid  (redirect_valid),
    .redirect_kind   (redirect_kind),
    .redirect_pc     (redirect_pc),
    .redirect_offset (redirect_offset),
    .redirect_target (redirect_target),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [63:0] t;
    if (reset) begin
      m_pc = 64'h0; m_addr = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
      m_req = 1'b0; m_valid = 1'b0; m_fault = 1'b0; m_discard = 1'b0;
    end else if (m_fault) begin
      m_fault = 1'b1;
    end else if (redirect_valid) begin
      t = redirect_kind ? redirect_target : redirect_pc + redirect_offset * 64'd4;
      if (t[1:0] != 2'b00) begin
        m_fault = 1'b1; m_req = 1'b0; m_valid = 1'b0;
      end else begin
        m_pc = t;
        m_valid = 1'b0;
        if (m_req && !imem_ack) begin
          m_discard = 1'b1;
        end else begin
          m_req = 1'b1; m_addr = t; m_discard = 1'b0;
        end
      end
    end else if (m_req && imem_ack) begin
      if (m_discard) begin
        m_discard = 1'b0;
        m_addr = m_pc;
      end else begin
        m_instr = imem_rdata; m_ipc = m_addr; m_valid = 1'b1;
        m_pc = m_pc + 64'd4; m_req = 1'b0;
      end
    end else if (m_valid && decode_ready) begin
      m_valid = 1'b0; m_req = 1'b1; m_addr = m_pc;
    end else if (!m_req && !m_valid) begin
      m_req = 1'b1; m_addr = m_pc;
    end
  endtask

  task automatic compare_all();
    check("req",   {63'h0, imem_req},    {63'h0, m_req});
    check("addr",  imem_addr,            m_addr);
    check("valid", {63'h0, instr_valid}, {63'h0, m_valid});
    check("instr", {32'h0, instr},       {32'h0, m_instr});
    check("ipc",   instr_pc,             m_ipc);
    check("fault", {63'h0, fault},       {63'h0, m_fault});
  endtask

  task automatic step(input logic rst, input logic ack, input logic [31:0] rdata,
                      input logic rdy, input logic rv, input logic kind,
                      input logic [63:0] rpc, input logic [63:0] off, input logic [63:0] tgt);
    reset = rst; imem_ack = ack; imem_rdata = rdata; decode_ready = rdy;
    redirect_valid = rv; redirect_kind = kind;
    redirect_pc = rpc; redirect_offset = off; redirect_target = tgt;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic s(input logic ack, input logic [31:0] rdata, input logic rdy);
    step(1'b0, ack, rdata, rdy, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
  endtask

  task automatic redir(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic kind, input logic [63:0] rpc,
                       input logic [63:0] off, input logic [63:0] tgt);
    step(1'b0, ack, rdata, rdy, 1'b1, kind, rpc, off, tgt);
  endtask

  initial begin
    int wait_cnt;
    logic [63:0] rpc, off, tgt;
    logic rv, kind, ack, rst;

    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_valid", {63'h0, instr_valid}, 64'h0);

    // Sequential fetch with ack two cycles after each request.
    s(1'b0, 32'h0, 1'b1);
    check("t1_req0", {63'h0, imem_req}, 64'h1);
    check("t1_addr0", imem_addr, 64'h0);
    s(1'b0, 32'h0, 1'b1);
    s(1'b1, 32'hAAAA0001, 1'b1);
    check("t1_valid0", {63'h0, instr_valid}, 64'h1);
    check("t1_ipc0", instr_pc, 64'h0);
    s(1'b0, 32'h0, 1'b1);
    check("t1_addr4", imem_addr, 64'h4);
    s(1'b0, 32'h0, 1'b1);
    s(1'b1, 32'hAAAA0002, 1'b1);
    check("t1_ipc4", instr_pc, 64'h4);
    s(1'b0, 32'h0, 1'b1);
    check("t1_addr8", imem_addr, 64'h8);

    // Decode stall holds the instruction and suppresses further requests.
    s(1'b0, 32'h0, 1'b0);
    s(1'b1, 32'h8B020020, 1'b0);
    for (int i = 0; i < 5; i++) begin
      s(1'b0, 32'h0, 1'b0);
      check("t2_instr", {32'h0, instr}, 64'h8B020020);
      check("t2_ipc", instr_pc, 64'h8);
      check("t2_noreq", {63'h0, imem_req}, 64'h0);
    end
    s(1'b0, 32'h0, 1'b1);
    check("t2_addr12", imem_addr, 64'hC);

    // PC-relative redirect in HOLD: 0x10 + (-2 << 2) = 0x08.
    s(1'b1, 32'h12345678, 1'b0);
    redir(1'b0, 32'h0, 1'b1, 1'b0, 64'h10, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
    check("t3_drop", {63'h0, instr_valid}, 64'h0);
    check("t3_addr", imem_addr, 64'h8);

    // Register redirect while a request is outstanding.
    redir(1'b0, 32'h0, 1'b1, 1'b1, 64'h0, 64'h0, 64'h100);
    check("t4_hold_addr", imem_addr, 64'h8);
    s(1'b0, 32'h0, 1'b1);
    s(1'b0, 32'h0, 1'b1);
    check("t4_still_old", imem_addr, 64'h8);
    s(1'b1, 32'hDEAD0001, 1'b1);
    check("t4_novalid", {63'h0, instr_valid}, 64'h0);
    check("t4_addr", imem_addr, 64'h100);

    // Redirect coincident with ack.
    redir(1'b1, 32'hDEAD0002, 1'b1, 1'b1, 64'h0, 64'h0, 64'h40);
    check("t5_novalid", {63'h0, instr_valid}, 64'h0);
    check("t5_addr", imem_addr, 64'h40);

    // PC wrap at the top of the address space.
    s(1'b1, 32'h0000_0040, 1'b0);
    redir(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    s(1'b1, 32'hFFFF0000, 1'b0);
    check("wrap_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    s(1'b0, 32'h0, 1'b1);
    check("wrap_addr", imem_addr, 64'h0);
    check("wrap_nofault", {63'h0, fault}, 64'h0);

    // Misaligned target faults and sticks until reset.
    redir(1'b0, 32'h0, 1'b1, 1'b1, 64'h0, 64'h0, 64'h102);
    check("t6_fault", {63'h0, fault}, 64'h1);
    check("t6_noreq", {63'h0, imem_req}, 64'h0);
    s(1'b1, 32'h55555555, 1'b1);
    redir(1'b0, 32'h0, 1'b1, 1'b1, 64'h0, 64'h0, 64'h200);
    s(1'b0, 32'h0, 1'b1);
    check("t6_sticky", {63'h0, fault}, 64'h1);
    check("t6_still_noreq", {63'h0, imem_req}, 64'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    check("t6_cleared", {63'h0, fault}, 64'h0);

    // Randomized traffic: memory acks only while a request is outstanding.
    wait_cnt = 1;
    for (int c = 0; c < 3000; c++) begin
      ack = 1'b0;
      if (m_req) begin
        if (wait_cnt == 0) begin
          ack = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
      rst  = ($urandom_range(0, 99) < 2);
      rv   = ($urandom_range(0, 99) < 12);
      kind = $urandom_range(0, 1);
      rpc  = {$urandom, $urandom};
      tgt  = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) begin
        rpc[1:0] = 2'b00;
        tgt[1:0] = 2'b00;
      end
      off = 64'($signed($urandom_range(0, 255)) - 128);
      step(rst, ack, $urandom, ($urandom_range(0, 2) != 0), rv, kind, rpc, off, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
